// File: rtl/mult_pkg.sv
// Shared types and elaboration helpers for the seq_mult_radix multiplier family.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    function automatic bit dividesEvenly(input int width, input int bitsPerCycle);
        return (bitsPerCycle > 0) && ((width % bitsPerCycle) == 0);
    endfunction

    // Legal shapes: even operand width of at least 4, digit of 1..8 bits that divides it.
    function automatic bit paramsOk(input int width, input int bitsPerCycle);
        return (width >= 4) && ((width % 2) == 0) && (bitsPerCycle <= 8)
               && dividesEvenly(width, bitsPerCycle);
    endfunction

endpackage

// File: rtl/mult_step.sv
// One radix step: adds the multiplicand times a BITS_PER_CYCLE-bit digit,
// aligned to the current shift, into the 2*WIDTH-bit accumulator.
module mult_step
    import mult_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int SHIFT_W        = clog2(WIDTH)
) (
    input  logic [2*WIDTH-1:0]        i_acc,
    input  logic [WIDTH-1:0]          i_mcand,
    input  logic [BITS_PER_CYCLE-1:0] i_digit,
    input  logic [SHIFT_W-1:0]        i_shift,
    output logic [2*WIDTH-1:0]        o_sum
);

    logic [2*WIDTH-1:0] w_mcandExt;
    logic [2*WIDTH-1:0] w_digitExt;
    logic [2*WIDTH-1:0] w_partial;

    assign w_mcandExt = {{WIDTH{1'b0}}, i_mcand};
    assign w_digitExt = {{(2*WIDTH-BITS_PER_CYCLE){1'b0}}, i_digit};
    assign w_partial  = w_mcandExt * w_digitExt;
    assign o_sum      = i_acc + (w_partial << i_shift);

endmodule

// File: rtl/seq_mult_radix.sv
// Sequential radix-2^BITS_PER_CYCLE shift-add multiplier with signed/unsigned mode.
// Optional early termination and cycles_used output: define SEQ_MULT_EARLY_TERM_EN.
module seq_mult_radix
    import mult_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    input  logic                 valid_data,
    input  logic                 ack,
    output logic [2*WIDTH-1:0]   producto,
    output logic                 Done_Flag,
    output logic                 busy
`ifdef SEQ_MULT_EARLY_TERM_EN
    ,
    output logic [clog2(WIDTH/BITS_PER_CYCLE+1)-1:0] cycles_used
`endif
);

    localparam int N       = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W   = clog2(N + 1);
    localparam int SHIFT_W = clog2(WIDTH);
    localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N);

    if (!paramsOk(WIDTH, BITS_PER_CYCLE)) begin : g_badParams
        $error("seq_mult_radix: WIDTH must be even and >= 4, BITS_PER_CYCLE must divide it");
    end

    state_t r_state;
    state_t w_stateNext;

    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [SHIFT_W-1:0] r_shift;
    logic [CNT_W-1:0]   r_count;
    logic               r_neg;
    logic [2*WIDTH-1:0] r_producto;
    logic               r_done;

    logic [WIDTH-1:0]   w_absA;
    logic [WIDTH-1:0]   w_absB;
    logic               w_negIn;
    logic [WIDTH-1:0]   w_mplierNext;
    logic [2*WIDTH-1:0] w_accNext;
    logic [2*WIDTH-1:0] w_result;
    logic               w_lastCycle;
    logic               w_accept;
    logic               w_finish;

    // Magnitudes are taken as unsigned, so the most negative value maps onto 2^(WIDTH-1).
    assign w_absA  = (signed_mode && a[WIDTH-1]) ? -a : a;
    assign w_absB  = (signed_mode && b[WIDTH-1]) ? -b : b;
    assign w_negIn = signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);

    assign w_mplierNext = r_mplier >> BITS_PER_CYCLE;

    mult_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE),
        .SHIFT_W        (SHIFT_W)
    ) u_step (
        .i_acc   (r_acc),
        .i_mcand (r_mcand),
        .i_digit (r_mplier[BITS_PER_CYCLE-1:0]),
        .i_shift (r_shift),
        .o_sum   (w_accNext)
    );

    assign w_result = r_neg ? -w_accNext : w_accNext;

`ifdef SEQ_MULT_EARLY_TERM_EN
    assign w_lastCycle = (r_count == CNT_W'(1)) || (w_mplierNext == '0);
`else
    assign w_lastCycle = (r_count == CNT_W'(1));
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_accept    = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (valid_data) begin
                    w_accept    = 1'b1;
                    w_stateNext = CALC;
                end
            end
            CALC: begin
                if (w_lastCycle) begin
                    w_finish    = 1'b1;
                    w_stateNext = DONE;
                end
            end
            // The ack edge only returns to IDLE, so a request needs one IDLE cycle.
            DONE: begin
                if (ack) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_acc      <= '0;
            r_shift    <= '0;
            r_count    <= '0;
            r_neg      <= 1'b0;
            r_producto <= '0;
            r_done     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mcand  <= w_absA;
                r_mplier <= w_absB;
                r_neg    <= w_negIn;
                r_acc    <= '0;
                r_shift  <= '0;
                r_count  <= N_CNT;
            end else if (r_state == CALC) begin
                r_acc    <= w_accNext;
                r_mplier <= w_mplierNext;
                r_shift  <= r_shift + SHIFT_W'(BITS_PER_CYCLE);
                r_count  <= r_count - CNT_W'(1);
            end

            if (w_finish) begin
                r_producto <= w_result;
                r_done     <= 1'b1;
            end else if ((r_state == DONE) && ack) begin
                r_done     <= 1'b0;
            end
        end
    end

`ifdef SEQ_MULT_EARLY_TERM_EN
    logic [CNT_W-1:0] r_cyclesUsed;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cyclesUsed <= '0;
        end else if (w_finish) begin
            r_cyclesUsed <= N_CNT - r_count + CNT_W'(1);
        end
    end

    assign cycles_used = r_cyclesUsed;
`endif

    assign producto  = r_producto;
    assign Done_Flag = r_done;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_seq_mult_radix.sv
// Bench for seq_mult_radix: a radix-2 (K=1) and a radix-16 (K=4) instance, both 32-bit,
// checked with vector tables, corner sequences and random operands against a product model.
module tb_seq_mult_radix;

    typedef struct {
        int          unit;
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [63:0] prod;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic        sm;

    logic        valid1, ack1, ackDrv1, ackLoop1, done1, busy1;
    logic [63:0] prod1;
    logic        valid4, ack4, done4, busy4;
    logic [63:0] prod4;
`ifdef SEQ_MULT_EARLY_TERM_EN
    logic [5:0]  used1;
    logic [3:0]  used4;
`endif

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk = ~clk;

    assign ack1 = ackLoop1 ? done1 : ackDrv1;

    seq_mult_radix #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut1 (
        .clk         (clk),
        .reset       (reset),
        .a           (a),
        .b           (b),
        .signed_mode (sm),
        .valid_data  (valid1),
        .ack         (ack1),
        .producto    (prod1),
        .Done_Flag   (done1),
        .busy        (busy1)
`ifdef SEQ_MULT_EARLY_TERM_EN
        ,
        .cycles_used (used1)
`endif
    );

    seq_mult_radix #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
        .clk         (clk),
        .reset       (reset),
        .a           (a),
        .b           (b),
        .signed_mode (sm),
        .valid_data  (valid4),
        .ack         (ack4),
        .producto    (prod4),
        .Done_Flag   (done4),
        .busy        (busy4)
`ifdef SEQ_MULT_EARLY_TERM_EN
        ,
        .cycles_used (used4)
`endif
    );

    // Reference: the mathematical product of the operands as read in the requested mode.
    function automatic logic [63:0] modelProduct(input logic [31:0] x, input logic [31:0] y,
                                                 input logic sgn);
        longint sx;
        longint sy;
        if (sgn) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        return {32'b0, x} * {32'b0, y};
    endfunction

    function automatic int expLatency(input logic [31:0] y, input logic sgn, input int k);
`ifdef SEQ_MULT_EARLY_TERM_EN
        logic [31:0] mag;
        int          lat;
        mag = (sgn && y[31]) ? -y : y;
        lat = 1;
        mag = mag >> k;
        while (mag != 0) begin
            lat++;
            mag = mag >> k;
        end
        return lat;
`else
        return 32 / k;
`endif
    endfunction

    function automatic logic [63:0] prodOf(input int unit);
        return (unit == 4) ? prod4 : prod1;
    endfunction

    function automatic logic doneOf(input int unit);
        return (unit == 4) ? done4 : done1;
    endfunction

    function automatic logic busyOf(input int unit);
        return (unit == 4) ? busy4 : busy1;
    endfunction

    task automatic setValid(input int unit, input logic v);
        if (unit == 4) valid4 = v;
        else           valid1 = v;
    endtask

    task automatic setAck(input int unit, input logic v);
        if (unit == 4) ack4    = v;
        else           ackDrv1 = v;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: actual %h required %h", name, actual, expected);
        end
    endtask

    // Presents a request for one edge; operands are scrambled afterwards on purpose.
    task automatic applyStimulus(input int unit, input logic [31:0] ia, input logic [31:0] ib,
                                 input logic isg);
        @(negedge clk);
        a  = ia;
        b  = ib;
        sm = isg;
        setValid(unit, 1'b1);
        @(posedge clk);
        #1;
        setValid(unit, 1'b0);
        a  = $urandom;
        b  = $urandom;
        sm = 1'($urandom_range(0, 1));
    endtask

    task automatic waitDone(input int unit, output int cycles);
        cycles = 0;
        while (!doneOf(unit) && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic runOp(input int unit, input logic [31:0] ia, input logic [31:0] ib,
                         input logic isg, input logic [63:0] expProd, input string tag);
        int cycles;
        applyStimulus(unit, ia, ib, isg);
        waitDone(unit, cycles);
        checkOutput({tag, "_lat"}, 64'(cycles), 64'(expLatency(ib, isg, unit)));
        checkOutput({tag, "_prod"}, prodOf(unit), expProd);
`ifdef SEQ_MULT_EARLY_TERM_EN
        checkOutput({tag, "_used"}, (unit == 4) ? 64'(used4) : 64'(used1),
                    64'(expLatency(ib, isg, unit)));
`endif
        setAck(unit, 1'b1);
        @(posedge clk);
        #1;
        setAck(unit, 1'b0);
        checkOutput({tag, "_idle"}, {62'b0, busyOf(unit), doneOf(unit)}, 64'b0);
        checkOutput({tag, "_kept"}, prodOf(unit), expProd);
    endtask

    initial begin
        vec_t        vecs[5];
        int          cycles;
        logic [63:0] held;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;

        vecs[0] = '{unit: 1, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, sgn: 1'b0, prod: 64'hFFFFFFFE00000001};
        vecs[1] = '{unit: 1, a: 32'hFFFFFFFD, b: 32'h00000005, sgn: 1'b1, prod: 64'hFFFFFFFFFFFFFFF1};
        vecs[2] = '{unit: 1, a: 32'h80000000, b: 32'h80000000, sgn: 1'b1, prod: 64'h4000000000000000};
        vecs[3] = '{unit: 1, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, sgn: 1'b1, prod: 64'h0000000000000001};
        vecs[4] = '{unit: 4, a: 32'h12345678, b: 32'h9ABCDEF0, sgn: 1'b0, prod: 64'h0B00EA4E242D2080};

        reset    = 1'b0;
        a        = '0;
        b        = '0;
        sm       = 1'b0;
        valid1   = 1'b0;
        ackDrv1  = 1'b0;
        ackLoop1 = 1'b0;
        valid4   = 1'b0;
        ack4     = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("reset_prod1", prod1, 64'b0);
        checkOutput("reset_done1", 64'(done1), 64'b0);
        checkOutput("reset_busy1", 64'(busy1), 64'b0);
        checkOutput("reset_prod4", prod4, 64'b0);
        checkOutput("reset_done4", 64'(done4), 64'b0);
        checkOutput("reset_busy4", 64'(busy4), 64'b0);
        reset = 1'b1;

        $display("[TB] vector table");
        for (int i = 0; i < 5; i++) begin
            runOp(vecs[i].unit, vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].prod,
                  $sformatf("vec%0d", i));
        end

        $display("[TB] ack tied to Done_Flag");
        ackLoop1 = 1'b1;
        applyStimulus(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        waitDone(1, cycles);
        checkOutput("loop_lat", 64'(cycles), 64'(expLatency(32'hFFFFFFFF, 1'b0, 1)));
        checkOutput("loop_prod", prod1, 64'hFFFFFFFE00000001);
        @(posedge clk);
        #1;
        checkOutput("loop_idle", {62'b0, busy1, done1}, 64'b0);
        checkOutput("loop_kept", prod1, 64'hFFFFFFFE00000001);
        ackLoop1 = 1'b0;

        $display("[TB] K=4 hold with ack low");
        applyStimulus(4, 32'h12345678, 32'h9ABCDEF0, 1'b0);
        waitDone(4, cycles);
        checkOutput("hold_lat", 64'(cycles), 64'(expLatency(32'h9ABCDEF0, 1'b0, 4)));
        checkOutput("hold_prod", prod4, 64'h0B00EA4E242D2080);
        for (int i = 0; i < 20; i++) begin
            a      = $urandom;
            b      = $urandom;
            valid4 = (i < 19);
            @(posedge clk);
            #1;
            checkOutput($sformatf("hold_prod_c%0d", i), prod4, 64'h0B00EA4E242D2080);
            checkOutput($sformatf("hold_done_c%0d", i), 64'(done4), 64'd1);
        end
        ack4 = 1'b1;
        @(posedge clk);
        #1;
        ack4 = 1'b0;
        checkOutput("hold_release", {62'b0, busy4, done4}, 64'b0);

        $display("[TB] asynchronous reset during CALC");
        applyStimulus(1, 32'hDEADBEEF, 32'hFFFFFFFF, 1'b0);
        repeat (9) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("midreset_prod", prod1, 64'b0);
        checkOutput("midreset_done", 64'(done1), 64'b0);
        checkOutput("midreset_busy", 64'(busy1), 64'b0);
        @(negedge clk);
        reset = 1'b1;
        runOp(1, 32'd2, 32'd3, 1'b0, 64'd6, "recover");

        $display("[TB] request together with ack");
        applyStimulus(1, 32'h00010001, 32'hFFFF0000, 1'b0);
        waitDone(1, cycles);
        checkOutput("b2b_first", prod1, modelProduct(32'h00010001, 32'hFFFF0000, 1'b0));
        a       = 32'h7FFFFFFF;
        b       = 32'h80000001;
        sm      = 1'b1;
        ackDrv1 = 1'b1;
        valid1  = 1'b1;
        @(posedge clk);
        #1;
        ackDrv1 = 1'b0;
        checkOutput("b2b_gap_busy", 64'(busy1), 64'b0);
        checkOutput("b2b_gap_done", 64'(done1), 64'b0);
        @(posedge clk);
        #1;
        valid1 = 1'b0;
        checkOutput("b2b_accept_busy", 64'(busy1), 64'd1);
        waitDone(1, cycles);
        checkOutput("b2b_lat", 64'(cycles), 64'(expLatency(32'h80000001, 1'b1, 1)));
        checkOutput("b2b_prod", prod1, modelProduct(32'h7FFFFFFF, 32'h80000001, 1'b1));
        ackDrv1 = 1'b1;
        @(posedge clk);
        #1;
        ackDrv1 = 1'b0;

        $display("[TB] random operands");
        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            if (i == 0) rb = 32'd0;
            if (i == 1) rb = 32'd1;
            if (i == 2) rb = 32'h80000000;
            runOp((i % 2 == 1) ? 4 : 1, ra, rb, rs, modelProduct(ra, rb, rs),
                  $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
